// File: rtl/mem_pkg.sv
// Shared types and constants for the data-memory access stage.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC0 = 2'd1,
        ACC1 = 2'd2,
        DONE = 2'd3
    } mem_state_t;

    // Byte enables are big-endian: lane 0 is bits [31:24].
    localparam logic [3:0] BE_WORD = 4'b1111;
    localparam logic [3:0] BE_B0   = 4'b1000;
    localparam logic [3:0] BE_B1   = 4'b0100;
    localparam logic [3:0] BE_B2   = 4'b0010;
    localparam logic [3:0] BE_B3   = 4'b0001;

    localparam int unsigned TIMEOUT_DEFAULT = 255;

    function automatic logic addr_aligned(input logic [2:0] low_addr, input logic access64,
                                          input logic byte_acc);
        if (access64) begin
            return low_addr == 3'b000;
        end else if (byte_acc) begin
            return 1'b1;
        end
        return low_addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/mem_byte_lane.sv
// Byte-lane steering: enable generation, store replication, load extract with sign extension.
module mem_byte_lane
    import mem_pkg::*;
(
    input  logic [1:0]  lane,
    input  logic [7:0]  store_byte,
    input  logic [31:0] rdata,
    output logic [3:0]  byte_be,
    output logic [31:0] store_word,
    output logic [31:0] load_sext
);

    logic [7:0] load_byte;

    always_comb begin
        byte_be   = BE_B0;
        load_byte = rdata[31:24];
        unique case (lane)
            2'd0: begin
                byte_be   = BE_B0;
                load_byte = rdata[31:24];
            end
            2'd1: begin
                byte_be   = BE_B1;
                load_byte = rdata[23:16];
            end
            2'd2: begin
                byte_be   = BE_B2;
                load_byte = rdata[15:8];
            end
            2'd3: begin
                byte_be   = BE_B3;
                load_byte = rdata[7:0];
            end
            default: begin
                byte_be   = BE_B0;
                load_byte = rdata[31:24];
            end
        endcase
    end

    assign store_word = {4{store_byte}};
    assign load_sext  = {{24{load_byte[7]}}, load_byte};

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage access unit: multi-beat handshake with a 32-bit data memory, big-endian 64-bit
// accesses, alignment and timeout errors, and pipeline stall generation.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic [31:0] Adrs_MEM,
    input  logic [31:0] Store_data,
    input  logic [63:0] Store_data64,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        Access64,
    input  logic        ByteAcc,
    output logic [31:0] mem_addr,
    output logic        mem_re,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic [31:0] OUT_data_MEM,
    output logic [63:0] OUT_data64_MEM,
    output logic        Stall_MEM,
    output logic        AddrErr,
    output logic        BusErr
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    mem_state_t      state_q, state_d;
    logic [CntW-1:0] wait_q, wait_d;
    logic [31:0]     hi_q, hi_d;
    logic [31:0]     data_q, data_d;
    logic [63:0]     data64_q, data64_d;
    logic            addr_err_q, addr_err_d;
    logic            bus_err_q, bus_err_d;

    logic        request, is_load, is_store, byte_op, aligned, in_acc, timeout;
    logic [31:0] word_addr;
    logic [3:0]  lane_be;
    logic [31:0] lane_store, lane_load;

    // A simultaneous read and write is handled as a read.
    assign request   = MemRead | MemWrite;
    assign is_load   = MemRead;
    assign is_store  = MemWrite & ~MemRead;
    assign byte_op   = ByteAcc & ~Access64;
    assign aligned   = addr_aligned(Adrs_MEM[2:0], Access64, ByteAcc);
    assign in_acc    = (state_q == ACC0) || (state_q == ACC1);
    assign word_addr = {Adrs_MEM[31:2], 2'b00};
    assign timeout   = in_acc & ~mem_ready & (wait_q == CntW'(TIMEOUT - 1));

    mem_byte_lane u_byte_lane (
        .lane       (Adrs_MEM[1:0]),
        .store_byte (Store_data[7:0]),
        .rdata      (mem_rdata),
        .byte_be    (lane_be),
        .store_word (lane_store),
        .load_sext  (lane_load)
    );

    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        hi_d       = hi_q;
        data_d     = data_q;
        data64_d   = data64_q;
        addr_err_d = 1'b0;
        bus_err_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (request) begin
                    if (aligned) begin
                        state_d = ACC0;
                        wait_d  = '0;
                    end else begin
                        state_d    = DONE;
                        addr_err_d = 1'b1;
                        if (is_load && Access64) data64_d = '0;
                        if (is_load && !Access64) data_d = '0;
                    end
                end
            end
            ACC0: begin
                if (mem_ready) begin
                    if (Access64) begin
                        if (is_load) hi_d = mem_rdata;
                        state_d = ACC1;
                        wait_d  = '0;
                    end else begin
                        if (is_load) data_d = byte_op ? lane_load : mem_rdata;
                        state_d = DONE;
                    end
                end else if (timeout) begin
                    state_d   = DONE;
                    bus_err_d = 1'b1;
                    if (is_load && Access64) data64_d = '0;
                    if (is_load && !Access64) data_d = '0;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            ACC1: begin
                if (mem_ready) begin
                    if (is_load) data64_d = {hi_q, mem_rdata};
                    state_d = DONE;
                end else if (timeout) begin
                    state_d   = DONE;
                    bus_err_d = 1'b1;
                    if (is_load) data64_d = '0;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q    <= IDLE;
            wait_q     <= '0;
            hi_q       <= '0;
            data_q     <= '0;
            data64_q   <= '0;
            addr_err_q <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            hi_q       <= hi_d;
            data_q     <= data_d;
            data64_q   <= data64_d;
            addr_err_q <= addr_err_d;
            bus_err_q  <= bus_err_d;
        end
    end

    // The first 64-bit beat carries the high word; the second beat goes to address + 4.
    always_comb begin
        mem_addr  = '0;
        mem_be    = '0;
        mem_wdata = '0;
        if (in_acc) begin
            mem_addr = (state_q == ACC1) ? word_addr + 32'd4 : word_addr;
            mem_be   = byte_op ? lane_be : BE_WORD;
            if (Access64) begin
                mem_wdata = (state_q == ACC1) ? Store_data64[31:0] : Store_data64[63:32];
            end else if (byte_op) begin
                mem_wdata = lane_store;
            end else begin
                mem_wdata = Store_data;
            end
        end
    end

    assign mem_re         = in_acc & MemRead;
    assign mem_we         = in_acc & is_store;
    // Gated by reset so the stall drops at once even with a request still pending.
    assign Stall_MEM      = Rst_n & (((state_q == IDLE) & request & aligned) | in_acc);
    assign OUT_data_MEM   = data_q;
    assign OUT_data64_MEM = data64_q;
    assign AddrErr        = addr_err_q;
    assign BusErr         = bus_err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a small responding memory model.
module tb_mem_access_unit;

    logic        Clk;
    logic        Rst_n;
    logic [31:0] Adrs_MEM;
    logic [31:0] Store_data;
    logic [63:0] Store_data64;
    logic        MemRead, MemWrite, Access64, ByteAcc;
    logic [31:0] mem_addr;
    logic        mem_re, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic [31:0] OUT_data_MEM;
    logic [63:0] OUT_data64_MEM;
    logic        Stall_MEM, AddrErr, BusErr;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] mem [logic [31:0]];
    logic [31:0] addr_log[$];
    logic [3:0]  be_log[$];
    logic [31:0] wd_log[$];
    int          re_cycles, we_cycles;
    int          ready_delay;
    int          waited;
    logic        stuck_low;
    int          sc;

    mem_access_unit #(.TIMEOUT(4)) dut (
        .Clk            (Clk),
        .Rst_n          (Rst_n),
        .Adrs_MEM       (Adrs_MEM),
        .Store_data     (Store_data),
        .Store_data64   (Store_data64),
        .MemRead        (MemRead),
        .MemWrite       (MemWrite),
        .Access64       (Access64),
        .ByteAcc        (ByteAcc),
        .mem_addr       (mem_addr),
        .mem_re         (mem_re),
        .mem_we         (mem_we),
        .mem_be         (mem_be),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .mem_ready      (mem_ready),
        .OUT_data_MEM   (OUT_data_MEM),
        .OUT_data64_MEM (OUT_data64_MEM),
        .Stall_MEM      (Stall_MEM),
        .AddrErr        (AddrErr),
        .BusErr         (BusErr)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Memory responder: ready after ready_delay wait cycles per beat, writes merged by byte enable.
    always @(negedge Clk) begin
        if (mem_re || mem_we) begin
            if (mem_re) re_cycles++;
            if (mem_we) we_cycles++;
            if (!stuck_low && waited >= ready_delay) begin
                logic [31:0] cur;
                mem_ready = 1'b1;
                cur = mem.exists(mem_addr) ? mem[mem_addr] : 32'h0;
                mem_rdata = cur;
                addr_log.push_back(mem_addr);
                be_log.push_back(mem_be);
                wd_log.push_back(mem_wdata);
                if (mem_we) begin
                    for (int b = 0; b < 4; b++) begin
                        if (mem_be[b]) cur[b*8 +: 8] = mem_wdata[b*8 +: 8];
                    end
                    mem[mem_addr] = cur;
                end
                waited = 0;
            end else begin
                mem_ready = 1'b0;
                waited++;
            end
        end else begin
            mem_ready = 1'b0;
            mem_rdata = 32'h0;
            waited    = 0;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_logs();
        addr_log.delete();
        be_log.delete();
        wd_log.delete();
        re_cycles = 0;
        we_cycles = 0;
    endtask

    task automatic issue(input logic [31:0] adrs, input logic rd, input logic wr,
                         input logic a64, input logic bacc);
        clear_logs();
        @(posedge Clk);
        #1;
        Adrs_MEM = adrs;
        MemRead  = rd;
        MemWrite = wr;
        Access64 = a64;
        ByteAcc  = bacc;
    endtask

    task automatic end_req();
        @(posedge Clk);
        #1;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        Access64 = 1'b0;
        ByteAcc  = 1'b0;
    endtask

    // Counts stalled cycles from the request cycle; returns at the DONE negedge.
    task automatic wait_done(output int stall_cycles);
        stall_cycles = 0;
        @(negedge Clk);
        while (Stall_MEM && stall_cycles < 30) begin
            stall_cycles++;
            @(negedge Clk);
        end
    endtask

    initial begin
        Rst_n        = 1'b0;
        Adrs_MEM     = '0;
        Store_data   = '0;
        Store_data64 = '0;
        MemRead      = 1'b0;
        MemWrite     = 1'b0;
        Access64     = 1'b0;
        ByteAcc      = 1'b0;
        mem_ready    = 1'b0;
        mem_rdata    = '0;
        ready_delay  = 0;
        waited       = 0;
        stuck_low    = 1'b0;
        clear_logs();

        #2;
        check("rst_stall", Stall_MEM, 0);
        check("rst_re_we", {mem_re, mem_we}, 0);
        check("rst_data", OUT_data_MEM, 0);
        check("rst_data64", OUT_data64_MEM, 0);
        check("rst_errs", {AddrErr, BusErr}, 0);
        @(posedge Clk);
        #1 Rst_n = 1'b1;

        // Word load, zero-wait memory.
        mem[32'h100] = 32'hDEADBEEF;
        issue(32'h100, 1, 0, 0, 0);
        wait_done(sc);
        check("wl_stall_cycles", sc, 2);
        check("wl_data", OUT_data_MEM, 32'hDEADBEEF);
        check("wl_addr", addr_log.size() > 0 ? addr_log[0] : 32'hX, 32'h100);
        check("wl_be", be_log.size() > 0 ? be_log[0] : 4'hX, 4'hF);
        check("wl_errs", {AddrErr, BusErr}, 0);
        end_req();

        // 64-bit load with two wait cycles per beat.
        mem[32'h208] = 32'h11223344;
        mem[32'h20C] = 32'h55667788;
        ready_delay  = 2;
        issue(32'h208, 1, 0, 1, 0);
        wait_done(sc);
        check("dl_stall_cycles", sc, 7);
        check("dl_data64", OUT_data64_MEM, 64'h1122334455667788);
        check("dl_beats", addr_log.size(), 2);
        check("dl_addr0", addr_log.size() > 0 ? addr_log[0] : 32'hX, 32'h208);
        check("dl_addr1", addr_log.size() > 1 ? addr_log[1] : 32'hX, 32'h20C);
        check("dl_re_cycles", re_cycles, 6);
        check("dl_data_hold", OUT_data_MEM, 32'hDEADBEEF);
        end_req();
        ready_delay = 0;

        // Byte load from lane 3, negative byte.
        mem[32'h100] = 32'h000000F0;
        issue(32'h103, 1, 0, 0, 1);
        wait_done(sc);
        check("bl_stall_cycles", sc, 2);
        check("bl_be", be_log.size() > 0 ? be_log[0] : 4'hX, 4'b0001);
        check("bl_data", OUT_data_MEM, 32'hFFFFFFF0);
        check("bl_data64_hold", OUT_data64_MEM, 64'h1122334455667788);
        end_req();

        // Byte store to lane 1.
        Store_data = 32'h123456A5;
        issue(32'h101, 0, 1, 0, 1);
        wait_done(sc);
        check("bs_stall_cycles", sc, 2);
        check("bs_be", be_log.size() > 0 ? be_log[0] : 4'hX, 4'b0100);
        check("bs_wdata", wd_log.size() > 0 ? wd_log[0] : 32'hX, 32'hA5A5A5A5);
        check("bs_we_cycles", we_cycles, 1);
        check("bs_data_hold", OUT_data_MEM, 32'hFFFFFFF0);
        check("bs_mem", mem[32'h100], 32'h00A500F0);
        end_req();

        // Misaligned word load.
        issue(32'h102, 1, 0, 0, 0);
        @(negedge Clk);
        check("ma_stall", Stall_MEM, 0);
        check("ma_re", mem_re, 0);
        @(negedge Clk);
        check("ma_addr_err", AddrErr, 1);
        check("ma_data", OUT_data_MEM, 0);
        check("ma_re_cycles", re_cycles, 0);
        end_req();
        @(negedge Clk);
        check("ma_addr_err_pulse", AddrErr, 0);

        // 64-bit load with ready stuck low; TIMEOUT is 4.
        stuck_low = 1'b1;
        issue(32'h200, 1, 0, 1, 0);
        wait_done(sc);
        check("to_stall_cycles", sc, 5);
        check("to_bus_err", BusErr, 1);
        check("to_data64", OUT_data64_MEM, 0);
        check("to_beats", addr_log.size(), 0);
        check("to_re_cycles", re_cycles, 4);
        end_req();
        stuck_low = 1'b0;
        @(negedge Clk);
        check("to_bus_err_pulse", BusErr, 0);

        // Reset during the second beat of a 64-bit store.
        Store_data64 = 64'hCAFEF00D_01234567;
        issue(32'h300, 0, 1, 1, 0);
        @(negedge Clk);
        check("rs_stall_c0", Stall_MEM, 1);
        @(negedge Clk);
        check("rs_wdata_hi", mem_wdata, 32'hCAFEF00D);
        @(negedge Clk);
        check("rs_addr_acc1", mem_addr, 32'h304);
        check("rs_wdata_lo", mem_wdata, 32'h01234567);
        check("rs_we_acc1", mem_we, 1);
        #2 Rst_n = 1'b0;
        #1;
        check("rs_we_drop", mem_we, 0);
        check("rs_stall_drop", Stall_MEM, 0);
        check("rs_no_rollback", mem[32'h300], 32'hCAFEF00D);
        MemWrite = 1'b0;
        Access64 = 1'b0;
        @(posedge Clk);
        #1 Rst_n = 1'b1;
        @(negedge Clk);
        check("rs_idle_stall", Stall_MEM, 0);
        check("rs_data64", OUT_data64_MEM, 0);

        // Normal operation resumes from IDLE after reset.
        issue(32'h100, 1, 0, 0, 0);
        wait_done(sc);
        check("pr_stall_cycles", sc, 2);
        check("pr_data", OUT_data_MEM, 32'h00A500F0);
        end_req();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Data-memory access stage sitting directly upstream of the MEM/WB pipeline register. It takes the address, store data and memory controls from EX/MEM, and runs a multi-beat handshake with a 32-bit data memory, including two beats for 64-bit FP accesses. It produces the 32-bit and 64-bit load results that MEM/WB captures as `OUT_data_MEM` / `OUT_data64_MEM`, and stalls the pipeline while an access is in flight.

## Interface
- `TIMEOUT`, 255: maximum wait cycles for `mem_ready` per beat before a bus error.
- `Clk` in 1: single clock, rising edge.
- `Rst_n` in 1: asynchronous, active-low reset.
- `Adrs_MEM` in 32: byte address from ALU.
- `Store_data` in 32: store data for word/byte stores.
- `Store_data64` in 64: store data for 64-bit stores.
- `MemRead` in 1: load request.
- `MemWrite` in 1: store request (`MemRead`&`MemWrite` both high = illegal, treated as read).
- `Access64` in 1: 64-bit access.
- `ByteAcc` in 1: byte access (ignored when `Access64`=1).
- `mem_addr` out 32: memory word address (bits [1:0] always 0).
- `mem_re` / `mem_we` out 1: memory read / write strobe.
- `mem_be` out 4: byte enables, bit 3 = bits [31:24].
- `mem_wdata` out 32: write data.
- `mem_rdata` in 32: read data, valid when `mem_ready`=1.
- `mem_ready` in 1: beat-complete handshake.
- `OUT_data_MEM` out 32: word load result, or sign-extended byte.
- `OUT_data64_MEM` out 64: 64-bit load result.
- `Stall_MEM` out 1: freeze PC/IF/ID/EX/MEM and force bubble controls into MEM/WB.
- `AddrErr` out 1: one-cycle misalignment pulse.
- `BusErr` out 1: one-cycle timeout pulse.

## Operation
- FSM states: IDLE, ACC0, ACC1, DONE.
- IDLE
  - Request (`MemRead`|`MemWrite`) → ACC0.
  - Alignment: 64-bit needs `Adrs_MEM[2:0]`=0; word needs `[1:0]`=0; byte has no requirement.
  - Misaligned → DONE with `AddrErr` pulse. No memory strobe is issued and the load result is forced to 0.
  - No request → stay in IDLE.
- ACC0
  - Drives `mem_addr`={`Adrs_MEM[31:2]`,2'b00} and the strobe.
  - On `mem_ready`: a load captures `mem_rdata`. Then go to ACC1 if `Access64`, else DONE.
- ACC1
  - Drives address +4 (wraps modulo 2^32) and the strobe.
  - On `mem_ready`: capture, then DONE.
- DONE: results valid for one cycle, then IDLE.
- Big-endian layout:
  - 64-bit: beat at A → [63:32], beat at A+4 → [31:0].
  - Store64 writes `Store_data64[63:32]` first.
- Byte access
  - Lane is set by `Adrs_MEM[1:0]`: 0→`mem_be`=1000, 1→0100, 2→0010, 3→0001.
  - Store byte: `mem_wdata`={4{`Store_data[7:0]`}}.
  - Load byte: selected lane sign-extended into `OUT_data_MEM`.
- Word access: `mem_be`=1111.
- Strobes are low in IDLE/DONE. `mem_wdata`/`mem_be` are don't-care when no strobe.
- Wait counter
  - Cleared on entry to ACC0/ACC1; counts cycles with `mem_ready`=0.
  - Reaching `TIMEOUT` → DONE with `BusErr` pulse, load data 0, and the remaining beat abandoned.
- `OUT_data_MEM`/`OUT_data64_MEM` are registered and hold until the next load's DONE. Stores do not change them.

## Timing
- Reset, asynchronous: state=IDLE; all outputs 0, including `mem_re`/`mem_we`, `Stall_MEM`, data, and errors.
  - Reset mid-access drops strobes immediately. A half-written 64-bit store is not rolled back.
- `Stall_MEM` = (IDLE & request & aligned) | ACC0 | ACC1, combinational. It is low in DONE, so EX/MEM advances on the DONE→IDLE edge and MEM/WB captures the valid result on that same edge.
- Latency with zero-wait memory (request at cycle 0):
  - Word/byte: ACC0 at cycle 1, DONE at cycle 2 (3 cycles).
  - 64-bit: DONE at cycle 3 (4 cycles).
  - Each wait cycle adds 1.
- Misaligned: DONE at cycle 1, no stall.
- `mem_ready` is sampled only in ACC0/ACC1. Ready in IDLE/DONE is ignored.
- `AddrErr`/`BusErr` are registered and asserted during DONE only.

## Structure
- Package `mem_pkg`:
  - `mem_state_t` enum {IDLE, ACC0, ACC1, DONE}.
  - Byte-enable constants BE_WORD/BE_B0..BE_B3.
  - `TIMEOUT_DEFAULT`.
- Sub-module `mem_byte_lane` (combinational): byte-enable generation, store-byte replication, load-byte extract and sign-extend.

## Test plan
- Word load at 0x100, `mem_rdata`=0xDEADBEEF, ready immediate → `Stall_MEM` high 2 cycles; `OUT_data_MEM`=0xDEADBEEF at DONE.
- 64-bit load at 0x208, beats 0x11223344 then 0x55667788, ready delayed 2 cycles per beat → addresses 0x208, 0x20C; `OUT_data64_MEM`=0x1122334455667788 at cycle 7.
- Byte load at 0x103, word 0x000000F0 → `mem_be` 0001; `OUT_data_MEM`=0xFFFFFFF0.
- Byte store 0xA5 at 0x101 → `mem_be`=0100, `mem_wdata`=0xA5A5A5A5, one `mem_we` cycle.
- Word load at 0x102 → no strobe; `AddrErr` one cycle; `OUT_data_MEM`=0. Then 64-bit load with `mem_ready` stuck low and TIMEOUT=4 → `BusErr` at DONE.
- `Rst_n` asserted in ACC1 of a 64-bit store → `mem_we`/`Stall_MEM` low immediately; state IDLE.
